// File: rtl/hadd_serial_arb.sv
// Two-requester round-robin front end for a shared bit-serial adder.
// Each add runs LSB-first through a two-half-adder full-adder slice over W cycles.
module hadd_serial_arb #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ0,
    input  logic [W-1:0] A0,
    input  logic [W-1:0] B0,
    input  logic         REQ1,
    input  logic [W-1:0] A1,
    input  logic [W-1:0] B1,
    output logic         ACK0,
    output logic         ACK1,
    output logic         BUSY,
    output logic         DONE0,
    output logic         DONE1,
    output logic         GNT_ID,
    output logic [W-1:0] SUM,
    output logic         COUT
);
    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q, b_q, res_q, sum_q;
    logic [CntW-1:0] cnt_q;
    logic            carry_q, prio_q, gnt_q, cout_q, busy_q;
    logic            ack0_q, ack1_q, done0_q, done1_q;

    // Half adder: {carry, sum}.
    function automatic logic [1:0] hadd(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [1:0]   h1, h2;
    logic         sum_bit, carry_next, gnt_sel;
    logic [W-1:0] res_next;

    always_comb begin
        h1         = hadd(a_q[0], b_q[0]);
        h2         = hadd(h1[0], carry_q);
        sum_bit    = h2[0];
        carry_next = h1[1] | h2[1];
        res_next   = res_q >> 1;
        res_next[W-1] = sum_bit;
        // On a tie the requester not served last wins.
        gnt_sel    = (REQ0 && REQ1) ? prio_q : REQ1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (REQ0 || REQ1) begin
                        a_q     <= gnt_sel ? A1 : A0;
                        b_q     <= gnt_sel ? B1 : B0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        gnt_q   <= gnt_sel;
                        ack0_q  <= ~gnt_sel;
                        ack1_q  <= gnt_sel;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_next;
                    carry_q <= carry_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(W - 1)) begin
                        sum_q   <= res_next;
                        cout_q  <= carry_next;
                        done0_q <= ~gnt_q;
                        done1_q <= gnt_q;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    prio_q  <= ~gnt_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ACK0   = ack0_q;
    assign ACK1   = ack1_q;
    assign BUSY   = busy_q;
    assign DONE0  = done0_q;
    assign DONE1  = done1_q;
    assign GNT_ID = gnt_q;
    assign SUM    = sum_q;
    assign COUT   = cout_q;

endmodule

// File: tb/tb_hadd_serial_arb.sv
// Randomized and directed bench for hadd_serial_arb against a transaction-level model.
module tb_hadd_serial_arb;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         ack0, ack1, busy, done0, done1, gnt_id, cout;
    logic [W-1:0] sum;

    hadd_serial_arb #(.W(W)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ0(req0), .A0(a0), .B0(b0),
        .REQ1(req1), .A1(a1), .B1(b1),
        .ACK0(ack0), .ACK1(ack1), .BUSY(busy),
        .DONE0(done0), .DONE1(done1), .GNT_ID(gnt_id),
        .SUM(sum), .COUT(cout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit hold0 = 1'b0, hold1 = 1'b0;

    // Model: a transaction is granted, its result a+b is known at once, and it
    // becomes visible W edges later; the block is free again one edge after that.
    bit           m_active = 1'b0;
    int           m_age = 0;
    bit           m_prio = 1'b0;
    bit           m_g = 1'b0;
    logic [W:0]   m_full = '0;
    logic [W-1:0] e_sum = '0;
    logic         e_cout = 1'b0, e_gnt = 1'b0, e_busy = 1'b0;
    logic         e_ack0 = 1'b0, e_ack1 = 1'b0, e_done0 = 1'b0, e_done1 = 1'b0;

    always @(posedge clk) begin
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0; m_age = 0; m_prio = 1'b0;
            e_sum = '0; e_cout = 1'b0; e_gnt = 1'b0; e_busy = 1'b0;
        end else if (!m_active) begin
            if (req0 || req1) begin
                m_g      = (req0 && req1) ? m_prio : req1;
                m_full   = m_g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
                m_active = 1'b1;
                m_age    = 0;
                e_gnt    = m_g;
                e_busy   = 1'b1;
                if (m_g) e_ack1 = 1'b1; else e_ack0 = 1'b1;
            end
        end else begin
            m_age++;
            if (m_age == W) begin
                e_sum  = m_full[W-1:0];
                e_cout = m_full[W];
                if (m_g) e_done1 = 1'b1; else e_done0 = 1'b1;
            end else if (m_age == W + 1) begin
                e_busy   = 1'b0;
                m_active = 1'b0;
                m_prio   = ~m_g;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("ACK0", 32'(ack0), 32'(e_ack0));
        check("ACK1", 32'(ack1), 32'(e_ack1));
        check("BUSY", 32'(busy), 32'(e_busy));
        check("DONE0", 32'(done0), 32'(e_done0));
        check("DONE1", 32'(done1), 32'(e_done1));
        check("GNT_ID", 32'(gnt_id), 32'(e_gnt));
        check("SUM", 32'(sum), 32'(e_sum));
        check("COUT", 32'(cout), 32'(e_cout));
        // Requesters drop REQ in their ACK cycle unless told to keep it.
        if (ack0 && !hold0) req0 = 1'b0;
        if (ack1 && !hold1) req1 = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        // Reset held with REQ0 pending, then released.
        req0 = 1'b1; a0 = 8'h0F; b0 = 8'h01;
        run(2);
        rst_n = 1'b1;
        run(12);
        // Overflow on requester 1.
        req1 = 1'b1; a1 = 8'hFF; b1 = 8'h01;
        run(12);
        // Both requesters held: alternating grants.
        hold0 = 1'b1; hold1 = 1'b1;
        req0 = 1'b1; a0 = 8'h21; b0 = 8'h43;
        req1 = 1'b1; a1 = 8'h80; b1 = 8'h91;
        run(42);
        hold0 = 1'b0; hold1 = 1'b0;
        run(25);
        // Reset in the middle of a RUN.
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
        run(5);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 8'hAA; b0 = 8'h55;
        run(12);
        // Operand change right after the grant.
        req0 = 1'b1; a0 = 8'h3C; b0 = 8'hC3;
        run(2);
        a0 = 8'h01; b0 = 8'hFE;
        run(11);
        // Random traffic with occasional resets and post-grant operand noise.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n = ($urandom_range(0, 199) != 0);
            if (ack0 && !req0) a0 = pick();
            if (ack1 && !req1) a1 = pick();
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; a0 = pick(); b0 = pick();
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; a1 = pick(); b1 = pick();
            end
            hold0 = ($urandom_range(0, 3) == 0);
            hold1 = ($urandom_range(0, 3) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hadd_serial_arb.md
Name: hadd_serial_arb

Overview:
Two-requester scheduler that shares one bit-serial adder datapath, built from two `hadd` instances forming a full-adder slice plus a carry register.
- Arbitrates between requesters round-robin and latches the granted operands.
- Sequences the add LSB-first over W cycles, then returns SUM/COUT with a one-cycle DONE pulse to the granted requester.
- Sits between client logic and the shared half-adder datapath.

Parameters:
W, 8, operand/sum width in bits (legal range 1..32)

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  synchronous active-low reset, sampled on rising CLK
REQ0  input  1  requester 0 request; held high until ACK0
A0  input  W  requester 0 operand A; stable while REQ0 high
B0  input  W  requester 0 operand B; stable while REQ0 high
REQ1  input  1  requester 1 request; held high until ACK1
A1  input  W  requester 1 operand A
B1  input  W  requester 1 operand B
ACK0  output  1  one-cycle pulse: requester 0 request accepted, operands captured
ACK1  output  1  one-cycle pulse: requester 1 request accepted
BUSY  output  1  high in RUN and DONE states
DONE0  output  1  one-cycle pulse: requester 0 result valid
DONE1  output  1  one-cycle pulse: requester 1 result valid
GNT_ID  output  1  id of requester currently or last served
SUM  output  W  result A+B mod 2^W; holds until next DONE
COUT  output  1  carry out of bit W-1; holds until next DONE

Behaviour:
- Reset (RST_N=0 at an edge): state=IDLE; all outputs 0; carry and shift registers 0; bit counter 0; round-robin pointer favours requester 0.
- Reset mid-operation abandons the add: no DONE, SUM/COUT forced to 0.
- States: IDLE, RUN, DONE.
- IDLE, no REQ: stay.
- IDLE, any REQ at edge k:
  - Grant: if only one REQ is high, grant it. If both are high, grant the one not served last (requester 0 on the first tie after reset).
  - Capture the grantee's A/B into shift registers; carry=0; counter=0; GNT_ID=grantee; ACK of grantee high for cycle k+1 only; go to RUN.
- RUN, each edge:
  - Bit slice: h1=hadd(a_lsb,b_lsb); h2=hadd(h1.sum,carry); sum_bit=h2.sum; carry<=h1.carry|h2.carry.
  - Shift sum_bit into the result register MSB-first, so after W shifts bit 0 is at the LSB.
  - Shift operands right; counter+1.
  - On the W-th RUN edge (edge k+W): load the result into SUM and the final carry into COUT; go to DONE.
- DONE: DONEx (x=GNT_ID) high for exactly one cycle (cycle k+W+1); update pointer to last-served=GNT_ID; next edge to IDLE.
- Latency: DONE asserted in cycle k+W+1. Next grant is possible at edge k+W+2, giving a throughput of one add per W+2 cycles.
- REQ of the grantee should drop in its ACK cycle. If it is still high when the block returns to IDLE, it is treated as a new request and arbitrated normally.
- The non-granted REQ is ignored (not queued) until IDLE; its operands are not sampled.
- Operand changes after the grant edge have no effect.
- W=1: a single RUN cycle; SUM=A^B, COUT=A&B.
- Wrap-around: sum is modulo 2^W; overflow is visible only on COUT.
- BUSY=1 in RUN and DONE; 0 in IDLE.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with REQ0=1 -> all outputs 0, no ACK; release -> ACK0 next cycle.
- W=8, REQ0 with A0=0x0F, B0=0x01 -> ACK0 in cycle k+1, DONE0 in cycle k+9, SUM=0x10, COUT=0, GNT_ID=0, BUSY high cycles k+1..k+9.
- Overflow: REQ1 with A1=0xFF, B1=0x01 -> DONE1, SUM=0x00, COUT=1, GNT_ID=1; DONE0 stays 0.
- REQ0 and REQ1 held continuously with different operands for 4 ops -> grants alternate 0,1,0,1, ACK pulses one cycle each, consecutive grants 10 cycles apart, each SUM correct for its requester.
- Reset asserted during RUN (counter=3) -> no DONE pulse, SUM=0, COUT=0; next REQ0 with A0=0xAA, B0=0x55 completes with SUM=0xFF, COUT=0.
- Operand change: alter A0 one cycle after ACK0 -> result reflects the operands captured at the grant edge.
